// File: rtl/sweep_frame_pkg.sv
// Shared types, default frame words and CRC constants for the sweep frame packer.
// SWEEP_FRAME_CRC_EN enables the CRC word appended after the count word.
package sweep_frame_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DAC_W  = 10;

  localparam logic [WORD_W-1:0] HDR_WORD_DEF = 16'hA5A5;
  localparam logic [WORD_W-2:0] TRL_WORD_DEF = 15'h5A5A;

  localparam logic [WORD_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [WORD_W-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DAC,
    ST_PAYLOAD,
    ST_TRL,
    ST_CNT,
    ST_CRC,
    ST_DONE
  } state_t;

  // CRC-16-CCITT update over one word, MSB first.
  function automatic logic [WORD_W-1:0] crc16_step(input logic [WORD_W-1:0] crc,
                                                   input logic [WORD_W-1:0] data);
    logic [WORD_W-1:0] c;
    c = crc;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (c[WORD_W-1] ^ data[i]) c = {c[WORD_W-2:0], 1'b0} ^ CRC_POLY;
      else                       c = {c[WORD_W-2:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sweep_frame_buf.sv
// First-word-fall-through payload FIFO; pushes into a full FIFO and pops from an
// empty one are ignored, concurrent push and pop are allowed.
module sweep_frame_buf
  import sweep_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_data_c,
  output logic              o_full_c,
  output logic              o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_wr;
  logic              w_rd;

  assign o_full_c  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty_c = (r_wptr == r_rptr);
  assign w_wr      = i_push && !o_full_c;
  assign w_rd      = i_pop && !o_empty_c;
  assign o_data_c  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sweep_frame_packer.sv
// Frames each sweep DAC step as HDR, DAC code, payload, trailer, word count into
// the USB FIFO. Define SWEEP_FRAME_CRC_EN to append a CRC-16-CCITT word.
module sweep_frame_packer
  import sweep_frame_pkg::*;
#(
  parameter int unsigned       BUF_DEPTH    = 256,
  parameter int unsigned       IDLE_TIMEOUT = 1024,
  parameter logic [WORD_W-1:0] HDR_WORD     = HDR_WORD_DEF,
  parameter logic [WORD_W-2:0] TRL_WORD     = TRL_WORD_DEF
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              StepStart,
  input  logic [DAC_W-1:0]  DacCode,
  input  logic [WORD_W-1:0] MaxWords,
  input  logic [WORD_W-1:0] SweepACQData,
  input  logic              SweepACQData_en,
  output logic [WORD_W-1:0] OutData,
  output logic              OutData_en,
  input  logic              OutFull,
  output logic              DataTransmitDone,
  output logic              Overflow,
  output logic              Busy
);

  localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [DAC_W-1:0]  r_dac;
  logic [WORD_W-1:0] r_rx_cnt;
  logic [WORD_W-1:0] r_tx_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic              r_open;
  logic              r_overflow;
  logic              r_busy;
  logic              r_done;
  logic              r_out_en;
  logic [WORD_W-1:0] r_out_data;
  logic              w_start;
  logic              w_close;
  logic              w_in_word;
  logic              w_pop;
  logic              w_issue;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_buf_data;
  logic              w_buf_full;
  logic              w_buf_empty;
`ifdef SWEEP_FRAME_CRC_EN
  logic [WORD_W-1:0] r_crc;
`endif

  assign w_start   = StepStart && (r_state == ST_IDLE);
  assign w_close   = r_open && (((MaxWords != '0) && (r_rx_cnt == MaxWords)) ||
                                (r_timer == TMR_W'(IDLE_TIMEOUT)));
  assign w_in_word = r_open && !w_close && SweepACQData_en;

  sweep_frame_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .i_push    (w_in_word),
    .i_data    (SweepACQData),
    .i_pop     (w_pop),
    .o_data_c  (w_buf_data),
    .o_full_c  (w_buf_full),
    .o_empty_c (w_buf_empty)
  );

  // Input side: open from StepStart until word budget or idle timeout closes it.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open     <= 1'b0;
      r_rx_cnt   <= '0;
      r_timer    <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_open     <= 1'b1;
      r_rx_cnt   <= '0;
      r_timer    <= '0;
      r_overflow <= 1'b0;
    end else if (w_close) begin
      r_open <= 1'b0;
    end else if (r_open) begin
      if (SweepACQData_en) begin
        r_timer <= '0;
        if (r_rx_cnt != '1) r_rx_cnt <= r_rx_cnt + WORD_W'(1);
        if (w_buf_full)     r_overflow <= 1'b1;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Output side: one word per cycle whenever the USB FIFO has room.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_pop   = 1'b0;
    w_word  = '0;
    unique case (r_state)
      ST_IDLE: if (w_start) w_next = ST_HDR;
      ST_HDR: if (!OutFull) begin
        w_issue = 1'b1;
        w_word  = HDR_WORD;
        w_next  = ST_DAC;
      end
      ST_DAC: if (!OutFull) begin
        w_issue = 1'b1;
        w_word  = {(WORD_W-DAC_W)'(0), r_dac};
        w_next  = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (!w_buf_empty) begin
          if (!OutFull) begin
            w_issue = 1'b1;
            w_pop   = 1'b1;
            w_word  = w_buf_data;
          end
        end else if (!r_open) begin
          w_next = ST_TRL;
        end
      end
      ST_TRL: if (!OutFull) begin
        w_issue = 1'b1;
        w_word  = {r_overflow, TRL_WORD};
        w_next  = ST_CNT;
      end
      ST_CNT: if (!OutFull) begin
        w_issue = 1'b1;
        w_word  = r_tx_cnt;
`ifdef SWEEP_FRAME_CRC_EN
        w_next  = ST_CRC;
`else
        w_next  = ST_DONE;
`endif
      end
`ifdef SWEEP_FRAME_CRC_EN
      ST_CRC: if (!OutFull) begin
        w_issue = 1'b1;
        w_word  = r_crc;
        w_next  = ST_DONE;
      end
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_en   <= 1'b0;
      r_out_data <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_dac      <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_out_en <= w_issue;
      if (w_issue) r_out_data <= w_word;
      r_done <= (r_state == ST_DONE);
      if (w_start)                   r_busy <= 1'b1;
      else if (r_state == ST_DONE)   r_busy <= 1'b0;
      if (w_start) r_dac <= DacCode;
      if (w_start)    r_tx_cnt <= '0;
      else if (w_pop) r_tx_cnt <= r_tx_cnt + WORD_W'(1);
    end
  end

`ifdef SWEEP_FRAME_CRC_EN
  // Running CRC over every frame word issued before the CRC word itself.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)                            r_crc <= CRC_INIT;
    else if (w_start)                        r_crc <= CRC_INIT;
    else if (w_issue && r_state != ST_CRC)   r_crc <= crc16_step(r_crc, w_word);
  end
`endif

  assign OutData          = r_out_data;
  assign OutData_en       = r_out_en;
  assign DataTransmitDone = r_done;
  assign Overflow         = r_overflow;
  assign Busy             = r_busy;

endmodule

// File: tb/tb_sweep_frame_packer.sv
// Scoreboard bench for sweep_frame_packer: expected frame words are queued as
// stimulus is driven and compared against words captured from the FIFO port.
module tb_sweep_frame_packer;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StepStart = 1'b0;
  logic [9:0]  DacCode = '0;
  logic [15:0] MaxWords = '0;
  logic [15:0] SweepACQData = '0;
  logic        SweepACQData_en = 1'b0;
  logic [15:0] OutData;
  logic        OutData_en;
  logic        OutFull;
  logic        DataTransmitDone;
  logic        Overflow;
  logic        Busy;

  logic        bp_mode = 1'b0;
  logic        full_force = 1'b0;
  logic [31:0] cyc_n = '0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          done_cnt = 0;
  logic [15:0] m_crc;
  int          n_checks = 0;
  int          n_fail = 0;

  assign OutFull = bp_mode ? (cyc_n[1:0] != 2'b00) : full_force;

  sweep_frame_packer dut (
    .Clk              (Clk),
    .reset_n          (reset_n),
    .StepStart        (StepStart),
    .DacCode          (DacCode),
    .MaxWords         (MaxWords),
    .SweepACQData     (SweepACQData),
    .SweepACQData_en  (SweepACQData_en),
    .OutData          (OutData),
    .OutData_en       (OutData_en),
    .OutFull          (OutFull),
    .DataTransmitDone (DataTransmitDone),
    .Overflow         (Overflow),
    .Busy             (Busy)
  );

  always #5 Clk = ~Clk;

  // Capture everything the DUT writes, sampled mid-cycle.
  always @(negedge Clk) begin
    cyc_n = cyc_n + 1;
    if (OutData_en) obs_q.push_back(OutData);
    if (DataTransmitDone) done_cnt = done_cnt + 1;
  end

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int k = 0; k < 16; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w);
    m_crc = ref_crc(m_crc, w);
  endtask

  task automatic expect_close(input logic [15:0] trl, input logic [15:0] cnt);
    expect_word(trl);
    expect_word(cnt);
`ifdef SWEEP_FRAME_CRC_EN
    exp_q.push_back(m_crc);
`endif
  endtask

  task automatic start_step(input logic [9:0] dac);
    DacCode = dac;
    StepStart = 1'b1;
    tick(1);
    StepStart = 1'b0;
    m_crc = 16'hFFFF;
    expect_word(16'hA5A5);
    expect_word({6'b0, dac});
  endtask

  task automatic send_word(input logic [15:0] d, input bit keep);
    SweepACQData = d;
    SweepACQData_en = 1'b1;
    tick(1);
    SweepACQData_en = 1'b0;
    if (keep) expect_word(d);
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < budget) begin
      tick(1);
      cycles++;
      if (DataTransmitDone) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    n_checks++; if (OutData !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0000", OutData); end
    n_checks++; if (OutData_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b required 0", OutData_en); end
    n_checks++; if (DataTransmitDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", DataTransmitDone); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", Overflow); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", Busy); end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int base, nexp, d0, cyc;
    bit ok;
    logic [15:0] e;
    base = obs_q.size();
    d0 = done_cnt;
    MaxWords = 16'd4;
    start_step(10'h155);
    n_checks++; if (Busy !== 1'b1 || OutData_en !== 1'b0) begin
      n_fail++; $display("FAIL basic_lat1: Busy=%b en=%b required Busy=1 en=0", Busy, OutData_en); end
    tick(1);
    n_checks++; if (OutData_en !== 1'b1 || OutData !== 16'hA5A5) begin
      n_fail++; $display("FAIL basic_lat2: en=%b data=%h required en=1 data=a5a5", OutData_en, OutData); end
    for (int i = 1; i <= 4; i++) send_word(16'(i), 1'b1);
    expect_close(16'h5A5A, 16'h0004);
    wait_done(200, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done: no pulse within %0d cycles", cyc); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b required 0 at done", Busy); end
    tick(1);
    n_checks++; if (DataTransmitDone !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b required 0", DataTransmitDone); end
    tick(2);
    nexp = exp_q.size();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (base + i >= obs_q.size()) begin n_fail++; $display("FAIL basic_word%0d: missing, required %h", i, e); end
      else if (obs_q[base+i] !== e) begin n_fail++; $display("FAIL basic_word%0d: got %h required %h", i, obs_q[base+i], e); end
    end
    n_checks++; if (obs_q.size() != base + nexp) begin n_fail++; $display("FAIL basic_len: got %0d required %0d", obs_q.size() - base, nexp); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_ndone: got %0d required 1", done_cnt - d0); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b required 0", Overflow); end
  endtask

  task automatic test_backpressure();
    int base, nexp, cyc;
    bit ok;
    logic [15:0] e;
    base = obs_q.size();
    MaxWords = 16'd8;
    bp_mode = 1'b1;
    start_step(10'h2C3);
    for (int i = 0; i < 8; i++) send_word(16'h1000 + 16'(i), 1'b1);
    expect_close(16'h5A5A, 16'h0008);
    wait_done(500, cyc, ok);
    bp_mode = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done: no pulse within %0d cycles", cyc); end
    tick(2);
    nexp = exp_q.size();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (base + i >= obs_q.size()) begin n_fail++; $display("FAIL bp_word%0d: missing, required %h", i, e); end
      else if (obs_q[base+i] !== e) begin n_fail++; $display("FAIL bp_word%0d: got %h required %h", i, obs_q[base+i], e); end
    end
    n_checks++; if (obs_q.size() != base + nexp) begin n_fail++; $display("FAIL bp_len: got %0d required %0d", obs_q.size() - base, nexp); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf: got %b required 0", Overflow); end
  endtask

  task automatic test_overflow();
    int base, nexp, cyc;
    bit ok;
    logic [15:0] e;
    base = obs_q.size();
    MaxWords = 16'd300;
    full_force = 1'b1;
    start_step(10'h001);
    for (int i = 0; i < 300; i++) send_word(16'h2000 + 16'(i), i < 256);
    tick(2);
    n_checks++; if (Overflow !== 1'b1 || Busy !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: Overflow=%b Busy=%b required 1 1", Overflow, Busy); end
    n_checks++; if (obs_q.size() != base) begin n_fail++; $display("FAIL ovf_held: got %0d words while full, required 0", obs_q.size() - base); end
    full_force = 1'b0;
    expect_close(16'hDA5A, 16'h0100);
    wait_done(1000, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_done: no pulse within %0d cycles", cyc); end
    tick(2);
    nexp = exp_q.size();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (base + i >= obs_q.size()) begin n_fail++; $display("FAIL ovf_word%0d: missing, required %h", i, e); end
      else if (obs_q[base+i] !== e) begin n_fail++; $display("FAIL ovf_word%0d: got %h required %h", i, obs_q[base+i], e); end
    end
    n_checks++; if (obs_q.size() != base + nexp) begin n_fail++; $display("FAIL ovf_len: got %0d required %0d", obs_q.size() - base, nexp); end
    n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", Overflow); end
  endtask

  task automatic test_timeout();
    int base, nexp, cyc;
    bit ok;
    logic [15:0] e;
    base = obs_q.size();
    MaxWords = 16'd0;
    start_step(10'h0F0);
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL to_ovf_clear: got %b required 0", Overflow); end
    for (int i = 0; i < 5; i++) send_word(16'h3000 + 16'(i), 1'b1);
    expect_close(16'h5A5A, 16'h0005);
    wait_done(2000, cyc, ok);
    n_checks++; if (!ok || cyc < 1024 || cyc > 1034) begin
      n_fail++; $display("FAIL to_delay: done=%b after %0d cycles, required 1024..1034", ok, cyc); end
    tick(2);
    // Empty frame: header, DAC, trailer and a zero count only.
    start_step(10'h00F);
    expect_close(16'h5A5A, 16'h0000);
    wait_done(2000, cyc, ok);
    n_checks++; if (!ok || cyc < 1024 || cyc > 1034) begin
      n_fail++; $display("FAIL to_empty_delay: done=%b after %0d cycles, required 1024..1034", ok, cyc); end
    tick(2);
    nexp = exp_q.size();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (base + i >= obs_q.size()) begin n_fail++; $display("FAIL to_word%0d: missing, required %h", i, e); end
      else if (obs_q[base+i] !== e) begin n_fail++; $display("FAIL to_word%0d: got %h required %h", i, obs_q[base+i], e); end
    end
    n_checks++; if (obs_q.size() != base + nexp) begin n_fail++; $display("FAIL to_len: got %0d required %0d", obs_q.size() - base, nexp); end
  endtask

  task automatic test_reset_mid_frame();
    int base, nexp, d0, cyc;
    bit ok;
    logic [15:0] e;
    MaxWords = 16'd8;
    start_step(10'h0AA);
    for (int i = 0; i < 3; i++) send_word(16'h4000 + 16'(i), 1'b1);
    tick(4);
    reset_n = 1'b0;
    #2;
    n_checks++; if (OutData !== 16'h0 || OutData_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_out: data=%h en=%b required 0000 0", OutData, OutData_en); end
    n_checks++; if (Busy !== 1'b0 || Overflow !== 1'b0 || DataTransmitDone !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_flags: busy=%b ovf=%b done=%b required 0 0 0", Busy, Overflow, DataTransmitDone); end
    tick(2);
    reset_n = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    tick(10);
    n_checks++; if (done_cnt != d0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_nodone: pulses=%0d busy=%b required 0 0", done_cnt - d0, Busy); end
    base = obs_q.size();
    MaxWords = 16'd2;
    start_step(10'h3FF);
    send_word(16'hBEEF, 1'b1);
    send_word(16'h0000, 1'b1);
    expect_close(16'h5A5A, 16'h0002);
    wait_done(200, cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_reset_done: no pulse within %0d cycles", cyc); end
    tick(2);
    nexp = exp_q.size();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (base + i >= obs_q.size()) begin n_fail++; $display("FAIL mid_word%0d: missing, required %h", i, e); end
      else if (obs_q[base+i] !== e) begin n_fail++; $display("FAIL mid_word%0d: got %h required %h", i, obs_q[base+i], e); end
    end
    n_checks++; if (obs_q.size() != base + nexp) begin n_fail++; $display("FAIL mid_len: got %0d required %0d", obs_q.size() - base, nexp); end
  endtask

  initial begin
    m_crc = 16'hFFFF;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
